lkt_result_packer: RTL

LKT_RESULT_PACKER -- requirements
Module: lkt_result_packer

---
 rtl/lkt_result_packer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lkt_result_packer.sv
// Collects out-of-order lookup results into slot positions and emits one packed batch when all slots are filled.
// Optional: define LKT_PACK_PARITY_EN to add the per-slot out_parity output.
module lkt_result_packer #(
  parameter int unsigned RESULT_WIDTH = 3,
  parameter int unsigned NUM_LOOKUPS  = 8,
  parameter int unsigned IDX_W        = (NUM_LOOKUPS > 1) ? $clog2(NUM_LOOKUPS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IDX_W-1:0]                    in_idx,
  input  logic [RESULT_WIDTH-1:0]             in_result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_LOOKUPS*RESULT_WIDTH-1:0] out_data,
  output logic                                err_dup,
  output logic                                err_range,
  output logic [15:0]                         batch_cnt
`ifdef LKT_PACK_PARITY_EN
  ,
  output logic [NUM_LOOKUPS-1:0]              out_parity
`endif
);

  localparam int unsigned DATA_W = NUM_LOOKUPS * RESULT_WIDTH;
  localparam logic [NUM_LOOKUPS-1:0] ALL_FILLED = '1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [NUM_LOOKUPS-1:0]  fill_q, fill_d;
  logic [DATA_W-1:0]       data_q;
  logic [NUM_LOOKUPS-1:0]  sel_c;
  logic                    in_range_c;
  logic                    write_c;
  logic                    dup_c;
  logic                    range_c;
  logic                    out_fire_c;
  logic                    clear_c;

  // One-hot slot decode of the incoming index
  always_comb begin
    sel_c      = '0;
    in_range_c = (32'(in_idx) < NUM_LOOKUPS);
    for (int unsigned k = 0; k < NUM_LOOKUPS; k++) begin
      sel_c[k] = (32'(in_idx) == k);
    end
  end

  // Next-state and handshake decisions; flush overrides everything
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    in_ready   = 1'b0;
    write_c    = 1'b0;
    dup_c      = 1'b0;
    range_c    = 1'b0;
    out_fire_c = 1'b0;
    clear_c    = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = !flush;
        if (in_valid && !flush) begin
          if (!in_range_c) begin
            range_c = 1'b1;
          end else if (|(sel_c & fill_q)) begin
            dup_c = 1'b1;
          end else begin
            write_c = 1'b1;
            fill_d  = fill_q | sel_c;
            if (fill_d == ALL_FILLED) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready && !flush) begin
          out_fire_c = 1'b1;
          clear_c    = 1'b1;
          fill_d     = '0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (flush) begin
      clear_c = 1'b1;
      fill_d  = '0;
      state_d = COLLECT;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Slot storage, error pulses and batch counter; cleared slots read as zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      err_dup   <= 1'b0;
      err_range <= 1'b0;
      batch_cnt <= '0;
    end else begin
      err_dup   <= dup_c;
      err_range <= range_c;
      if (out_fire_c) batch_cnt <= batch_cnt + 16'd1;
      if (clear_c) begin
        data_q <= '0;
      end else if (write_c) begin
        for (int unsigned k = 0; k < NUM_LOOKUPS; k++) begin
          if (sel_c[k]) data_q[k*RESULT_WIDTH +: RESULT_WIDTH] <= in_result;
        end
      end
    end
  end

`ifdef LKT_PACK_PARITY_EN
  logic [NUM_LOOKUPS-1:0] parity_q;

  // Parity tracked alongside the slot data it protects
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= '0;
    end else if (clear_c) begin
      parity_q <= '0;
    end else if (write_c) begin
      for (int unsigned k = 0; k < NUM_LOOKUPS; k++) begin
        if (sel_c[k]) parity_q[k] <= ^in_result;
      end
    end
  end

  assign out_parity = parity_q;
`endif

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;

endmodule
